// File: rtl/hs4_rx_buffer.sv
// Responder end of the 4-phase req/ack byte link, queueing received bytes in a circular FIFO.
// Latency: a byte captured at edge k is acked and visible on out_data/out_valid right after edge k.
// Backpressure: ack is withheld while the FIFO is full; the consumer stalls the head with out_ready=0.
module hs4_rx_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [DATA_W-1:0]          last_byte_out,
    output logic [CNT_W-1:0]           rx_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Full test looks only at the registered count, so a pop never frees a slot in the same edge.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (req_in && (fifo_count != FULL_CNT)) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ack_out   = (state == ACK);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            last_byte_out <= '0;
            rx_count      <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]   <= data_in;
                wr_ptr        <= wr_ptr + 1'b1;
                last_byte_out <= data_in;
                rx_count      <= rx_count + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_hs4_rx_buffer.sv
// Bench for hs4_rx_buffer: a master/consumer driver plus a queue-based reference model.
// A second instance with a 4-bit byte counter shares all inputs to exercise counter wrap.
module tb_hs4_rx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;

    logic          ack_out, out_valid;
    logic [DW-1:0] out_data, last_byte_out;
    logic [2:0]    fifo_count;
    logic [15:0]   rx_count;

    logic          ack4, valid4;
    logic [DW-1:0] data4, last4;
    logic [2:0]    count4;
    logic [3:0]    rx_count4;

    always #5 clk = ~clk;

    hs4_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .fifo_count(fifo_count),
        .last_byte_out(last_byte_out), .rx_count(rx_count)
    );

    hs4_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack4), .out_valid(valid4), .out_data(data4),
        .out_ready(out_ready), .fifo_count(count4),
        .last_byte_out(last4), .rx_count(rx_count4)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] got[$];
    bit            m_ack;
    logic [DW-1:0] m_last;
    int unsigned   m_total;
    bit            rand_ready;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ack   = 1'b0;
        m_last  = '0;
        m_total = 0;
    endtask

    task automatic compare_all();
        check("ack", 32'(ack_out), 32'(m_ack));
        check("valid", 32'(out_valid), 32'(mq.size() != 0));
        check("count", 32'(fifo_count), 32'(mq.size()));
        if (mq.size() != 0) check("data", 32'(out_data), 32'(mq[0]));
        check("last", 32'(last_byte_out), 32'(m_last));
        check("rx16", 32'(rx_count), m_total % 65536);
        check("ack4", 32'(ack4), 32'(m_ack));
        check("valid4", 32'(valid4), 32'(mq.size() != 0));
        check("count4", 32'(count4), 32'(mq.size()));
        if (mq.size() != 0) check("data4", 32'(data4), 32'(mq[0]));
        check("last4", 32'(last4), 32'(m_last));
        check("rx4", 32'(rx_count4), m_total % 16);
    endtask

    // One clock: the model decides from the pre-edge inputs, then outputs are checked 1ns later.
    task automatic step();
        bit accept, take;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        accept = !m_ack && req_in && (mq.size() < DEPTH);
        take   = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (take) got.push_back(mq.pop_front());
        if (accept) begin
            mq.push_back(data_in);
            m_last = data_in;
            m_total++;
        end
        m_ack = m_ack ? req_in : accept;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        req_in = 1'b0;
        rst    = 1'b0;
        #3;
        model_clear();
        compare_all();
        check("rst_data", 32'(out_data), 32'h0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        data_in = b;
        req_in  = 1'b1;
        for (int i = 0; i < 200 && !ack_out; i++) step();
        if (!ack_out) check("ack_rise_timeout", 32'(ack_out), 32'h1);
        req_in = 1'b0;
        for (int i = 0; i < 200 && ack_out; i++) step();
        if (ack_out) check("ack_fall_timeout", 32'(ack_out), 32'h0);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 100 && mq.size() != 0; i++) step();
        step();
        check("drain_count", 32'(fifo_count), 32'h0);
        out_ready = 1'b0;
    endtask

    task automatic check_got(input string tag, input logic [DW-1:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(tag, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [DW-1:0] exp[$];
        logic [DW-1:0] b;
        rand_ready = 1'b0;

        // Single byte with an always-ready consumer.
        do_reset();
        out_ready = 1'b1;
        data_in   = 8'hA5;
        req_in    = 1'b1;
        step();
        check("t1_ack", 32'(ack_out), 32'h1);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", 32'(out_data), 32'hA5);
        step();
        check("t1_popped", 32'(out_valid), 32'h0);
        check("t1_last", 32'(last_byte_out), 32'hA5);
        check("t1_rx", 32'(rx_count), 32'h1);
        req_in = 1'b0;
        step();
        check("t1_ack_fall", 32'(ack_out), 32'h0);

        // Backpressure: fifth byte stalls until one slot is popped.
        do_reset();
        got.delete();
        out_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        data_in = 8'h55;
        req_in  = 1'b1;
        repeat (3) step();
        check("bp_stall_ack", 32'(ack_out), 32'h0);
        check("bp_full", 32'(fifo_count), 32'h4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_head", 32'(out_data), 32'h22);
        check("bp_no_passthru", 32'(ack_out), 32'h0);
        step();
        check("bp_ack_late", 32'(ack_out), 32'h1);
        req_in = 1'b0;
        step();
        drain();
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_got("bp_order", exp);

        // Simultaneous push and pop with two entries held.
        do_reset();
        got.delete();
        out_ready = 1'b0;
        send_byte(8'h31); send_byte(8'h32);
        data_in   = 8'h33;
        req_in    = 1'b1;
        out_ready = 1'b1;
        step();
        check("pp_count", 32'(fifo_count), 32'h2);
        check("pp_ack", 32'(ack_out), 32'h1);
        out_ready = 1'b0;
        req_in    = 1'b0;
        step();
        drain();
        exp = '{8'h31, 8'h32, 8'h33};
        check_got("pp_order", exp);

        // Pointer wrap with a randomly stalling consumer.
        do_reset();
        got.delete();
        rand_ready = 1'b1;
        exp.delete();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            exp.push_back(8'(i));
        end
        drain();
        check_got("wrap_order", exp);
        check("wrap_rx", 32'(rx_count), 32'd16);
        check("wrap_count", 32'(fifo_count), 32'h0);

        // Asynchronous reset while acking with three entries queued.
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02);
        data_in = 8'h03;
        req_in  = 1'b1;
        step();
        check("mr_ack_pre", 32'(ack_out), 32'h1);
        check("mr_count_pre", 32'(fifo_count), 32'h3);
        rst = 1'b0;
        #2;
        check("mr_ack", 32'(ack_out), 32'h0);
        check("mr_valid", 32'(out_valid), 32'h0);
        check("mr_count", 32'(fifo_count), 32'h0);
        model_clear();
        req_in = 1'b0;
        #2;
        rst       = 1'b1;
        out_ready = 1'b1;
        send_byte(8'h7E);
        check("mr_rx", 32'(rx_count), 32'h1);
        check("mr_last", 32'(last_byte_out), 32'h7E);

        // Seventeen bytes: the 4-bit counter wraps to 1.
        do_reset();
        out_ready = 1'b1;
        b = '0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b);
        end
        check("cw_rx4", 32'(rx_count4), 32'h1);
        check("cw_rx16", 32'(rx_count), 32'd17);
        check("cw_last4", 32'(last4), 32'(b));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hs4_rx_buffer.md
Name: hs4_rx_buffer

Overview:
- Responder end of the team's 4-phase req/ack byte link.
- Accepts bytes from a master FSM, acknowledges each transfer and queues the bytes in a small circular FIFO.
- Presents queued bytes to a downstream consumer over a valid/ready interface.
- Applies backpressure by withholding ack while the FIFO is full, so the link stalls instead of dropping data.

Parameters:
DATA_W, 8, width of data_in / out_data / last_byte_out
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, width of rx_count (total accepted bytes, wraps)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  reset, asynchronous, active-low; assertion clears all state immediately
req_in  input  1  request from master; same clock domain, no synchronizer
data_in  input  DATA_W  byte from master; stable while req_in=1
ack_out  output  1  acknowledge to master, registered
out_valid  output  1  FIFO non-empty
out_data  output  DATA_W  FIFO head entry; valid when out_valid=1
out_ready  input  1  consumer accepts head this cycle
fifo_count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH
last_byte_out  output  DATA_W  most recent accepted byte
rx_count  output  CNT_W  bytes accepted since reset, modulo 2^CNT_W

Behaviour:
- Reset (rst=0): state=IDLE, ack_out=0, pointers=0, fifo_count=0, out_valid=0, out_data=0, last_byte_out=0, rx_count=0.
- Reset is effective asynchronously, including mid-handshake: ack_out drops at once and queued bytes are discarded.
- FSM states: IDLE, ACK.
- IDLE, ack_out=0:
  - req_in=1 and fifo_count<DEPTH sampled at edge k: write data_in at wr_ptr; last_byte_out<=data_in; rx_count+1; go ACK. ack_out=1 after edge k.
  - req_in=1 and fifo_count==DEPTH: stay IDLE, ack_out=0, nothing written. Retried every cycle.
  - req_in=0: stay IDLE.
- ACK, ack_out=1:
  - Hold while req_in=1. No further capture, even if data_in changes.
  - req_in=0 sampled: go IDLE, ack_out=0 after that edge.
- Handshake: one byte per full req↑ ack↑ req↓ ack↓ cycle. Minimum 4 clocks per byte with a master reacting in one cycle.
- Full test uses the registered fifo_count only. With fifo_count==DEPTH, a pop at edge k does not allow a push at edge k; the push is accepted at edge k+1 at the earliest. No pass-through.
- Pop: out_valid && out_ready at edge k advances rd_ptr. out_data shows the new head after edge k.
- Push and pop in the same edge with 0<fifo_count<DEPTH: count unchanged, both pointers advance.
- Empty FIFO: out_ready ignored. First-word latency: byte captured at edge k gives out_valid=1 and out_data=byte after edge k.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0. fifo_count is tracked separately (0..DEPTH).
- out_data is driven from the storage array at rd_ptr. Registered or combinational read are both allowed, provided the timing above holds. Reads 0 when empty after reset.
- rx_count wraps 2^CNT_W-1 -> 0 silently.
- Protocol misuse (master raising req_in while ack_out=1 from a previous byte): not detected. The FSM only responds to the req_in level per the state rules above.

Test Plan:
- Single byte: rst released, out_ready=1, master sends 0xA5. Required: ack_out rises 1 cycle after req_in seen high; out_valid=1 with out_data=0xA5 same edge; pop next edge; last_byte_out=0xA5; rx_count=1; ack_out falls 1 cycle after req_in falls.
- Backpressure: out_ready=0, send 0x11,0x22,0x33,0x44,0x55. Required: four acks, fifo_count=4, fifth req_in held with ack_out=0. Then pulse out_ready for one cycle. Required: out_data 0x11 popped, ack for 0x55 follows one cycle later, FIFO order 0x22,0x33,0x44,0x55.
- Wrap-around: out_ready toggling pseudo-randomly while sending 0x00..0x0F. Required: consumer receives 0x00..0x0F in order, no loss or duplicate, rx_count=16, fifo_count returns to 0.
- Simultaneous push/pop at fifo_count=2. Required: fifo_count stays 2 across that edge and ordering is preserved.
- Reset mid-operation: assert rst while ack_out=1 and fifo_count=3. Required: ack_out, out_valid and fifo_count go 0 without a clock edge. After release, a new byte 0x7E transfers normally and rx_count=1.
- rx_count wrap (CNT_W=4 override): send 17 bytes. Required: rx_count=1 and last_byte_out equals the 17th byte.
